// File: rtl/csr_trap_unit_if.sv
// Execute-stage bundle between the decoder/pipeline and the M-mode CSR/trap unit.
// The master drives the decoder strobes and interrupt levels; the slave returns read data, kill and the redirect.
interface csr_trap_unit_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_write;
  logic        csr_read;
  logic        csr_set;
  logic        csr_clear;
  logic        mret;
  logic        illegal_instruction;
  logic        ext_irq;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        kill;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output instr_valid, pc, instr, csr_addr, csr_wdata,
           csr_write, csr_read, csr_set, csr_clear,
           mret, illegal_instruction, ext_irq, timer_irq,
    input  csr_rdata, kill, redirect_valid, redirect_pc
  );

  modport slave (
    input  instr_valid, pc, instr, csr_addr, csr_wdata,
           csr_write, csr_read, csr_set, csr_clear,
           mret, illegal_instruction, ext_irq, timer_irq,
    output csr_rdata, kill, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_unit.sv
// M-mode CSR file with 64-bit cycle/instret counters and a RUN/REDIR trap sequencer.
// Traps and mret kill the execute-stage instruction and issue a one-cycle registered fetch redirect.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  csr_trap_unit_if.slave bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  typedef enum logic {RUN, REDIR} state_t;
  state_t r_state, w_state_nxt;

  logic        r_mie, r_mpie, r_meie, r_mtie;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0] r_mcycle, r_minstret;
  logic        r_redir_vld;
  logic [31:0] r_redir_pc;

  logic        w_impl, w_csr_any, w_csr_mod, w_illegal;
  logic        w_irq_ext, w_irq_tmr, w_irq;
  logic        w_kill, w_trap, w_mret, w_csr_we, w_retire;
  logic [31:0] w_old, w_new, w_cause, w_tval;
  logic        w_cyc_lo_we, w_cyc_hi_we, w_ret_lo_we, w_ret_hi_we;

  // Read mux; w_impl doubles as the implemented-address decode for the illegal check.
  always_comb begin
    w_impl = 1'b1;
    w_old  = '0;
    case (bus.csr_addr)
      A_MSTATUS:   w_old = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
      A_MISA:      w_old = 32'h4000_0100;
      A_MIE:       w_old = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
      A_MTVEC:     w_old = r_mtvec;
      A_MSCRATCH:  w_old = r_mscratch;
      A_MEPC:      w_old = r_mepc;
      A_MCAUSE:    w_old = r_mcause;
      A_MTVAL:     w_old = r_mtval;
      A_MIP:       w_old = {20'd0, bus.ext_irq, 3'd0, bus.timer_irq, 7'd0};
      A_MCYCLE:    w_old = r_mcycle[31:0];
      A_MCYCLEH:   w_old = r_mcycle[63:32];
      A_MINSTRET:  w_old = r_minstret[31:0];
      A_MINSTRETH: w_old = r_minstret[63:32];
      A_MHARTID:   w_old = HART_ID;
      default:     w_impl = 1'b0;
    endcase
  end

  assign bus.csr_rdata = w_old;

  always_comb begin
    w_new = bus.csr_wdata;
    if (!bus.csr_write) begin
      if (bus.csr_set)        w_new = w_old | bus.csr_wdata;
      else if (bus.csr_clear) w_new = w_old & ~bus.csr_wdata;
    end
  end

  assign w_csr_any = bus.csr_write | bus.csr_read | bus.csr_set | bus.csr_clear;
  assign w_csr_mod = bus.csr_write | bus.csr_set | bus.csr_clear;
  assign w_illegal = bus.illegal_instruction | (w_csr_any & ~w_impl);
  assign w_irq_ext = r_mie & r_meie & bus.ext_irq;
  assign w_irq_tmr = r_mie & r_mtie & bus.timer_irq;
  assign w_irq     = w_irq_ext | w_irq_tmr;
  assign w_cause   = w_irq_ext ? 32'h8000_000B : (w_irq_tmr ? 32'h8000_0007 : 32'd2);
  assign w_tval    = w_irq ? 32'd0 : bus.instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kill      = 1'b0;
    w_trap      = 1'b0;
    w_mret      = 1'b0;
    w_csr_we    = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.instr_valid) begin
          if (w_irq || w_illegal) begin
            w_trap      = 1'b1;
            w_kill      = 1'b1;
            w_state_nxt = REDIR;
          end else if (bus.mret) begin
            w_mret      = 1'b1;
            w_kill      = 1'b1;
            w_state_nxt = REDIR;
          end else if (w_csr_mod) begin
            w_csr_we    = 1'b1;
          end
        end
      end
      REDIR: begin
        // Whatever sits in execute now is wrong-path.
        w_kill      = 1'b1;
        w_state_nxt = RUN;
      end
    endcase
  end

  assign bus.kill = w_kill;
  assign w_retire = (r_state == RUN) & bus.instr_valid & ~w_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_mtvec    <= {MTVEC_RESET[31:2], 2'b00};
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (w_trap) begin
      r_mepc   <= bus.pc & ~32'h3;
      r_mcause <= w_cause;
      r_mtval  <= w_tval;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (w_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_csr_we) begin
      case (bus.csr_addr)
        A_MSTATUS:  begin r_mie <= w_new[3]; r_mpie <= w_new[7]; end
        A_MIE:      begin r_mtie <= w_new[7]; r_meie <= w_new[11]; end
        A_MTVEC:    r_mtvec    <= w_new & ~32'h3;
        A_MSCRATCH: r_mscratch <= w_new;
        A_MEPC:     r_mepc     <= w_new & ~32'h3;
        A_MCAUSE:   r_mcause   <= w_new;
        A_MTVAL:    r_mtval    <= w_new;
        default: ;
      endcase
    end
  end

  assign w_cyc_lo_we = w_csr_we & (bus.csr_addr == A_MCYCLE);
  assign w_cyc_hi_we = w_csr_we & (bus.csr_addr == A_MCYCLEH);
  assign w_ret_lo_we = w_csr_we & (bus.csr_addr == A_MINSTRET);
  assign w_ret_hi_we = w_csr_we & (bus.csr_addr == A_MINSTRETH);

  // A software write to either half freezes the whole counter for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_cyc_lo_we)      r_mcycle[31:0]  <= w_new;
      else if (w_cyc_hi_we) r_mcycle[63:32] <= w_new;
      else                  r_mcycle        <= r_mcycle + 64'd1;

      if (w_ret_lo_we)      r_minstret[31:0]  <= w_new;
      else if (w_ret_hi_we) r_minstret[63:32] <= w_new;
      else if (w_retire)    r_minstret        <= r_minstret + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      r_redir_vld <= w_trap | w_mret;
      if (w_trap)      r_redir_pc <= r_mtvec;
      else if (w_mret) r_redir_pc <= r_mepc;
    end
  end

  assign bus.redirect_valid = r_redir_vld;
  assign bus.redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR ops, trap/mret sequencing, counters and reset mid-redirect.
module tb_csr_trap_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csr_trap_unit_if bus();

  csr_trap_unit #(.MTVEC_RESET(32'h0000_0100), .HART_ID(32'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.instr_valid = 1'b0; bus.pc = '0; bus.instr = '0;
    bus.csr_addr = '0; bus.csr_wdata = '0;
    bus.csr_write = 1'b0; bus.csr_read = 1'b0; bus.csr_set = 1'b0; bus.csr_clear = 1'b0;
    bus.mret = 1'b0; bus.illegal_instruction = 1'b0;
    bus.ext_irq = 1'b0; bus.timer_irq = 1'b0;
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled before the next one.
  task automatic step();
    @(posedge clk); #1;
    clr();
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a; #1;
    chk(tag, {32'd0, bus.csr_rdata}, {32'd0, exp});
  endtask

  // op: 0 write, 1 set, 2 clear
  task automatic csr_op(input logic [11:0] a, input logic [31:0] wd, input int op);
    bus.instr_valid = 1'b1; bus.csr_addr = a; bus.csr_wdata = wd;
    bus.csr_write = (op == 0); bus.csr_set = (op == 1); bus.csr_clear = (op == 2);
    step();
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rd("rst_mtvec", 12'h305, 32'h0000_0100);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mhartid", 12'hF14, 32'h0);
    chk("rst_rv", {63'd0, bus.redirect_valid}, 64'd0);

    bus.instr_valid = 1'b1; bus.csr_addr = 12'h340; bus.csr_wdata = 32'hA5A5_0F0F; bus.csr_write = 1'b1;
    #1 chk("csrw_kill", {63'd0, bus.kill}, 64'd0);
    step();
    csr_op(12'h340, 32'h0000_F000, 1);
    rd("csrs_mscratch", 12'h340, 32'hA5A5_FF0F);
    csr_op(12'h340, 32'hA5A5_0000, 2);
    rd("csrc_mscratch", 12'h340, 32'h0000_FF0F);
    csr_op(12'h305, 32'h0000_0203, 0);
    rd("mtvec_align", 12'h305, 32'h0000_0200);

    // Illegal instruction strobe
    bus.instr_valid = 1'b1; bus.pc = 32'h40; bus.instr = 32'hFFFF_FFFF; bus.illegal_instruction = 1'b1;
    #1 chk("ill_kill", {63'd0, bus.kill}, 64'd1);
    step();
    chk("ill_rv", {63'd0, bus.redirect_valid}, 64'd1);
    chk("ill_rpc", {32'd0, bus.redirect_pc}, 64'h200);
    bus.instr_valid = 1'b1;
    #1 chk("redir_kill", {63'd0, bus.kill}, 64'd1);
    step();
    chk("ill_rv_drop", {63'd0, bus.redirect_valid}, 64'd0);
    rd("ill_mepc", 12'h341, 32'h40);
    rd("ill_mcause", 12'h342, 32'd2);
    rd("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    rd("ill_mstatus", 12'h300, 32'h0000_1800);

    // Unimplemented CSR address
    bus.instr_valid = 1'b1; bus.pc = 32'h44; bus.instr = 32'h7C00_2573;
    bus.csr_addr = 12'h7C0; bus.csr_read = 1'b1;
    #1 chk("unimp_kill", {63'd0, bus.kill}, 64'd1);
    step();
    chk("unimp_rv", {63'd0, bus.redirect_valid}, 64'd1);
    chk("unimp_rpc", {32'd0, bus.redirect_pc}, 64'h200);
    step();
    rd("unimp_mepc", 12'h341, 32'h44);
    rd("unimp_mcause", 12'h342, 32'd2);
    rd("unimp_mtval", 12'h343, 32'h7C00_2573);

    // Interrupt outranks a simultaneous illegal instruction
    csr_op(12'h304, 32'h0000_0880, 0);
    csr_op(12'h300, 32'h0000_0008, 0);
    bus.instr_valid = 1'b1; bus.pc = 32'h50; bus.instr = 32'hFFFF_FFFF;
    bus.illegal_instruction = 1'b1; bus.ext_irq = 1'b1; bus.timer_irq = 1'b1;
    #1 chk("irq_kill", {63'd0, bus.kill}, 64'd1);
    step();
    chk("irq_rpc", {32'd0, bus.redirect_pc}, 64'h200);
    step();
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mtval", 12'h343, 32'h0);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);
    rd("irq_mepc", 12'h341, 32'h50);

    // mret back to 0x124; neither it nor the wrong-path slot retires
    csr_op(12'h341, 32'h0000_0124, 0);
    csr_op(12'hB02, 32'h0000_1000, 0);
    bus.instr_valid = 1'b1; bus.mret = 1'b1;
    #1 chk("mret_kill", {63'd0, bus.kill}, 64'd1);
    step();
    chk("mret_rv", {63'd0, bus.redirect_valid}, 64'd1);
    chk("mret_rpc", {32'd0, bus.redirect_pc}, 64'h124);
    bus.instr_valid = 1'b1; bus.csr_addr = 12'h340; bus.csr_wdata = 32'hDEAD; bus.csr_write = 1'b1;
    #1 chk("wrongpath_kill", {63'd0, bus.kill}, 64'd1);
    step();
    rd("wrongpath_nowr", 12'h340, 32'h0000_FF0F);
    rd("mret_minstret", 12'hB02, 32'h0000_1000);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // Ten retiring instructions
    repeat (10) begin
      bus.instr_valid = 1'b1; bus.csr_addr = 12'h340; bus.csr_read = 1'b1;
      step();
    end
    rd("instret_lo", 12'hB02, 32'h0000_100A);
    rd("instret_hi", 12'hB82, 32'h0);

    // mcycle carry into the high half
    csr_op(12'hB80, 32'd7, 0);
    csr_op(12'hB00, 32'hFFFF_FFFF, 0);
    rd("cyc_hi_wr", 12'hB80, 32'd7);
    rd("cyc_lo_wr", 12'hB00, 32'hFFFF_FFFF);
    step();
    rd("cyc_hi_carry", 12'hB80, 32'd8);
    rd("cyc_lo_wrap", 12'hB00, 32'd0);
    step();
    rd("cyc_lo_inc", 12'hB00, 32'd1);

    // Reset while a redirect is in flight
    bus.instr_valid = 1'b1; bus.pc = 32'h60; bus.illegal_instruction = 1'b1;
    step();
    chk("prerst_rv", {63'd0, bus.redirect_valid}, 64'd1);
    rst_n = 1'b0;
    #1 chk("rst_redir_rv", {63'd0, bus.redirect_valid}, 64'd0);
    chk("rst_redir_rpc", {32'd0, bus.redirect_pc}, 64'd0);
    step();
    rst_n = 1'b1;
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mtvec", 12'h305, 32'h0000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap sequencer for the RV32I-Trap core; consumes the decoder's CSR, `mret` and `illegal_instruction` strobes in the execute stage. It holds the M-mode CSRs and the 64-bit cycle/instret counters, and arbitrates interrupts, illegal-instruction exceptions and `mret`. For each trap or `mret` it kills the current instruction and issues a one-cycle registered PC redirect.

## Interface
- `MTVEC_RESET`, 32'h0000_0100, reset value of `mtvec`.
- `HART_ID`, 0, value returned by `mhartid`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  execute stage holds a real instruction this cycle.
- `pc`  in  32  PC of the execute-stage instruction.
- `instr`  in  32  raw instruction word; used for `mtval`.
- `csr_addr`  in  12  CSR address, instr[31:20].
- `csr_wdata`  in  32  operand: rs1 value or zero-extended zimm, already selected upstream.
- `csr_write`, `csr_read`, `csr_set`, `csr_clear`  in  1 each  decoder CSR strobes.
- `mret`, `illegal_instruction`  in  1 each  decoder strobes.
- `ext_irq`, `timer_irq`  in  1 each  level interrupt requests, synchronous to `clk`.
- `csr_rdata`  out  32  combinational old value of `csr_addr`; 0 when unimplemented.
- `kill`  out  1  combinational; suppresses register write, memory access and retire of the current instruction.
- `redirect_valid`  out  1  registered; one-cycle fetch redirect.
- `redirect_pc`  out  32  registered target; valid while `redirect_valid` is high.

## Operation
- Implemented CSRs:
  - `mstatus` (0x300): MIE bit 3, MPIE bit 7, MPP[12:11] hardwired to 2'b11; all other bits read 0.
  - `misa` (0x301): reads 32'h4000_0100.
  - `mie` (0x304): MTIE bit 7, MEIE bit 11 writable.
  - `mtvec` (0x305): direct mode only; bits [1:0] forced to 0.
  - `mscratch` (0x340): full 32-bit read/write.
  - `mepc` (0x341): bits [1:0] forced to 0.
  - `mcause` (0x342), `mtval` (0x343): full 32-bit.
  - `mip` (0x344): read-only; MTIP bit 7 = `timer_irq`, MEIP bit 11 = `ext_irq`.
  - `mcycle`/`mcycleh` (0xB00/0xB80) and `minstret`/`minstreth` (0xB02/0xB82): writable halves of the 64-bit counters.
  - `mhartid` (0xF14): reads `HART_ID`.
- Writes to `misa`, `mip` and `mhartid` are ignored and do not trap.
- CSR update: `csr_write` -> new = wdata; `csr_set` -> old | wdata; `csr_clear` -> old & ~wdata. Masking is applied after the operation.
- An access to an unimplemented address with any CSR strobe raises an illegal-instruction exception.
- FSM states: RUN, REDIR.
- RUN, `instr_valid` high: events are evaluated in priority order, and only the first one acts.
  1. Interrupt: `mstatus.MIE` set and (MEIE&`ext_irq` or MTIE&`timer_irq`). External beats timer. `mcause` = 32'h8000_000B or 32'h8000_0007; `mtval` = 0.
  2. Illegal: `illegal_instruction` high or unimplemented CSR address. `mcause` = 2; `mtval` = `instr`.
  3. `mret`.
  4. CSR operation.
- Trap entry (events 1 and 2):
  - `kill` = 1.
  - `mepc` <= `pc`.
  - MPIE <= MIE, MIE <= 0.
  - `redirect_pc` <= {`mtvec`[31:2], 2'b00}.
  - Go to REDIR.
- `mret`:
  - `kill` = 1; the instruction does not retire.
  - MIE <= MPIE, MPIE <= 1.
  - `redirect_pc` <= `mepc`.
  - Go to REDIR.
- REDIR:
  - `redirect_valid` = 1 for this one cycle.
  - `instr_valid` is treated as a wrong-path instruction: no event, no CSR write, no retire, `kill` = 1.
  - Always return to RUN.
- `mcycle` increments every cycle.
- `minstret` increments when RUN, `instr_valid`, and `kill` = 0.
- Both counters wrap at 2^64, with carry from the low half into the high half.
- A CSR write to a counter half in the same cycle takes precedence for the whole 64-bit counter: written half = new value, other half holds, no increment.
- Reset values:
  - State RUN; `redirect_valid` 0; `redirect_pc` 0.
  - `mtvec` = `MTVEC_RESET`; `mstatus` MIE and MPIE = 0.
  - `mie`, `mscratch`, `mepc`, `mcause`, `mtval` and both counters = 0.
- Reset mid-REDIR: the redirect is dropped and the block returns to RUN.

## Timing
- `csr_rdata` and `kill` are combinational in cycle N of the event.
- CSR, counter and status updates take effect at the end of cycle N.
- `redirect_valid` and `redirect_pc` are registered and visible in cycle N+1 only.
- Back-to-back events are impossible: cycle N+1 is always REDIR.
- A CSR read of a counter returns the pre-increment value.
- An instruction that reads `mstatus` in the cycle after an update sees the new value.
- Interrupts sample levels only in RUN with `instr_valid` high; there is no latching.

## Test plan
- Reset: after `rst_n` deasserts, read 0x305 -> 32'h0000_0100; read 0x300 -> 32'h0000_1800; read 0xF14 -> 0; `redirect_valid` = 0.
- CSR ops:
  - write 0x340 with 32'hA5A5_0F0F, then set with 32'h0000_F000 -> reads 32'hA5A5_FF0F.
  - then clear with 32'hA5A5_0000 -> reads 32'h0000_FF0F.
  - write 0x305 with 32'h0000_0203 -> reads 32'h0000_0200.
- Illegal: `illegal_instruction` with pc = 32'h40, instr = 32'hFFFF_FFFF.
  - `kill` = 1 in the same cycle.
  - Next cycle: `redirect_valid` = 1, `redirect_pc` = `mtvec`.
  - Afterwards: `mepc` = 32'h40, `mcause` = 2, `mtval` = 32'hFFFF_FFFF, MIE = 0.
  - A CSR access to 0x7C0 traps identically.
- Interrupt priority: MIE = 1, MEIE = MTIE = 1, both IRQs high, and `illegal_instruction` asserted in the same cycle -> `mcause` = 32'h8000_000B; `mtval` = 0; MPIE = 1.
- `mret`: set `mepc` = 32'h124, MPIE = 1, then `mret`.
  - `redirect_pc` = 32'h124 in the next cycle.
  - MIE = 1; `minstret` unchanged.
  - An `instr_valid` during REDIR does not retire.
- Counters:
  - write `mcycle` = 32'hFFFF_FFFF -> `mcycleh` increments two cycles later.
  - 10 valid non-trapping instructions -> `minstret` += 10.
  - Reset asserted during REDIR -> `redirect_valid` drops immediately.
